// File: rtl/vector_lsu.sv
// Vector load/store unit: one 32-bit element per cycle, bounds-checked against MEM_DEPTH.
// Optional macro VLSU_STRIDE_EN enables req_stride; without it, accesses are unit-stride.
module vector_lsu #(
  parameter int MEM_DEPTH = 31,
  parameter int NELEM     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [31:0]           req_base,
  input  logic [31:0]           req_stride,
  input  logic [2:0]            req_vl,
  input  logic [32*NELEM-1:0]   req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [32*NELEM-1:0]   rsp_rdata,
  output logic                  rsp_err,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [31:0]           mem_rdata
);

  localparam int unsigned IW = (NELEM > 1) ? $clog2(NELEM) : 1;

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t                  r_state, w_next;
  logic                    r_op;
  logic [31:0]             r_addr;
  logic [2:0]              r_vl;
  logic [IW-1:0]           r_idx;
  logic [NELEM-1:0][31:0]  r_wdata;
  logic [NELEM-1:0][31:0]  r_buf;
  logic                    r_err;

  logic                    w_accept;
  logic                    w_last;
  logic                    w_in_range;
  logic [2:0]              w_vl;
  logic [31:0]             w_stride;

`ifdef VLSU_STRIDE_EN
  logic [31:0] r_stride;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_stride <= '0;
    else if (w_accept) r_stride <= req_stride;
  end

  assign w_stride = r_stride;
`else
  logic w_unused_stride;
  assign w_unused_stride = ^req_stride;
  assign w_stride        = 32'd1;
`endif

  assign w_vl       = (req_vl > 3'(NELEM)) ? 3'(NELEM) : req_vl;
  assign w_accept   = (r_state == IDLE) && req_valid;
  assign w_last     = (3'(r_idx) == (r_vl - 3'd1));
  assign w_in_range = (r_addr < 32'(MEM_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = (w_vl == 3'd0) ? RESP : XFER;
      end
      XFER: begin
        mem_addr  = r_addr;
        mem_wdata = r_wdata[r_idx];
        mem_re    = ~r_op & w_in_range;
        mem_we    = r_op & w_in_range;
        if (w_last) w_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // base + idx*stride is kept as a running sum, stepped by stride per element (same value mod 2^32)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= 1'b0;
      r_addr  <= '0;
      r_vl    <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_buf   <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_op    <= req_op;
      r_addr  <= req_base;
      r_vl    <= w_vl;
      r_idx   <= '0;
      r_wdata <= req_wdata;
      r_buf   <= '0;
      r_err   <= 1'b0;
    end else if (r_state == XFER) begin
      if (!w_in_range) r_err <= 1'b1;
      else if (!r_op)  r_buf[r_idx] <= mem_rdata;
      r_addr <= r_addr + w_stride;
      if (!w_last) r_idx <= r_idx + IW'(1);
    end
  end

  assign rsp_rdata = r_buf;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_vector_lsu.sv
// Self-checking bench for vector_lsu: directed cases plus randomized requests
// against a word-array reference model of memory.
module tb_vector_lsu;

  localparam int NELEM     = 4;
  localparam int MEM_DEPTH = 31;
`ifdef VLSU_STRIDE_EN
  localparam bit STRIDE_EN = 1'b1;
`else
  localparam bit STRIDE_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                req_valid, req_ready, req_op;
  logic [31:0]         req_base, req_stride;
  logic [2:0]          req_vl;
  logic [32*NELEM-1:0] req_wdata;
  logic                rsp_valid, rsp_ready, rsp_err;
  logic [32*NELEM-1:0] rsp_rdata;
  logic [31:0]         mem_addr, mem_wdata, mem_rdata;
  logic                mem_we, mem_re;

  logic [31:0] mem     [0:MEM_DEPTH-1];
  logic [31:0] ref_mem [0:MEM_DEPTH-1];
  int          we_count = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  vector_lsu #(.MEM_DEPTH(MEM_DEPTH), .NELEM(NELEM)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_base(req_base), .req_stride(req_stride), .req_vl(req_vl),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] = i;
    end else if (mem_we) begin
      we_count++;
      if (mem_addr < 32'(MEM_DEPTH)) mem[mem_addr[4:0]] = mem_wdata;
    end
  end

  always_comb mem_rdata = (mem_addr < 32'(MEM_DEPTH)) ? mem[mem_addr[4:0]] : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = i;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    ref_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Entered and left at a negedge.
  task automatic do_req(input bit op, input logic [31:0] base, input logic [31:0] stride,
                        input logic [2:0] vl, input logic [127:0] wdata, input int unsigned hold,
                        output logic [127:0] got_rd, output logic got_err);
    int unsigned vle;
    int unsigned waited;
    logic [31:0] st, a;
    logic        inr;
    logic [127:0] exp_rd;
    logic        exp_err;
    st      = STRIDE_EN ? stride : 32'd1;
    vle     = (vl > 3'(NELEM)) ? NELEM : int'(vl);
    exp_rd  = '0;
    exp_err = 1'b0;
    got_rd  = 'x;
    got_err = 1'bx;

    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_op = op; req_base = base; req_stride = stride;
    req_vl = vl; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;

    for (int unsigned k = 0; k < vle; k++) begin
      a   = base + k * st;
      inr = (a < 32'(MEM_DEPTH));
      check("element", {req_ready, rsp_valid, mem_re, mem_we, mem_addr, mem_wdata},
            {1'b0, 1'b0, ~op & inr, op & inr, a, wdata[32*k +: 32]});
      if (!inr)     exp_err = 1'b1;
      else if (op)  ref_mem[a] = wdata[32*k +: 32];
      else          exp_rd[32*k +: 32] = ref_mem[a];
      @(posedge clk);
      @(negedge clk);
    end

    check("rsp_valid_on_time", rsp_valid, 1'b1);
    waited = 0;
    while (!rsp_valid && waited < 16) begin
      @(posedge clk);
      @(negedge clk);
      waited++;
    end
    if (!rsp_valid) begin
      check("rsp_timeout", rsp_valid, 1'b1);
      apply_reset();
      return;
    end

    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_flags", {rsp_err, mem_re, mem_we, req_ready}, {exp_err, 1'b0, 1'b0, 1'b0});
    got_rd  = rsp_rdata;
    got_err = rsp_err;

    for (int unsigned h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check("backpressure_hold", {rsp_valid, req_ready, mem_re, mem_we, rsp_err, rsp_rdata},
            {1'b1, 1'b0, 1'b0, 1'b0, exp_err, exp_rd});
    end

    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("release", {rsp_valid, req_ready}, {1'b0, 1'b1});
  endtask

  initial begin
    logic [127:0] rd;
    logic         err;
    int           we_before;
    bit           op;
    logic [31:0]  base, stride;
    logic [2:0]   vl;
    logic [127:0] wd;

    req_valid = 1'b0; req_op = 1'b0; req_base = '0; req_stride = '0;
    req_vl = '0; req_wdata = '0; rsp_ready = 1'b0;

    #1 rst = 1'b1;
    ref_reset();
    #2;
    check("reset_state",
          {req_ready, rsp_valid, rsp_err, mem_we, mem_re, mem_addr, mem_wdata},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0});
    check("reset_rdata", rsp_rdata, 128'd0);
    @(negedge clk);
    rst = 1'b0;

    // Unit-stride load from 4
    do_req(1'b0, 32'd4, 32'd1, 3'd4, '0, 0, rd, err);
    check("load4_value", {err, rd}, {1'b0, 32'd7, 32'd6, 32'd5, 32'd4});

    // Store then overlapping load
    we_before = we_count;
    do_req(1'b1, 32'd10, 32'd1, 3'd2, {32'd0, 32'd0, 32'hBB, 32'hAA}, 0, rd, err);
    check("store_we_pulses", we_count - we_before, 2);
    check("store_rdata_zero", {err, rd}, 129'd0);
    do_req(1'b0, 32'd10, 32'd1, 3'd3, '0, 0, rd, err);
    check("store_load_value", rd, {32'd0, 32'd12, 32'hBB, 32'hAA});

    // Strided load
    do_req(1'b0, 32'd0, 32'd3, 3'd4, '0, 0, rd, err);
    if (STRIDE_EN) check("stride_value", rd, {32'd9, 32'd6, 32'd3, 32'd0});
    else           check("stride_value", rd, {32'd3, 32'd2, 32'd1, 32'd0});

    // Running off the end of memory, then a clean request clears err
    do_req(1'b0, 32'd29, 32'd1, 3'd4, '0, 0, rd, err);
    check("oor_value", {err, rd}, {1'b1, 32'd0, 32'd0, 32'd30, 32'd29});
    do_req(1'b0, 32'd0, 32'd1, 3'd1, '0, 0, rd, err);
    check("oor_err_cleared", {err, rd}, {1'b0, 128'd0});

    // Backpressure, vl=0, vl clamp, address wrap
    do_req(1'b0, 32'd20, 32'd1, 3'd2, '0, 3, rd, err);
    we_before = we_count;
    do_req(1'b1, 32'd5, 32'd1, 3'd0, {4{32'hFFFF_FFFF}}, 1, rd, err);
    check("vl0_no_writes", we_count - we_before, 0);
    do_req(1'b0, 32'd0, 32'd1, 3'd7, '0, 0, rd, err);
    check("clamp_value", rd, {32'd3, 32'd2, 32'd1, 32'd0});
    do_req(1'b0, 32'hFFFF_FFFF, 32'd1, 3'd3, '0, 0, rd, err);
    check("wrap_value", {err, rd}, {1'b1, 32'd0, 32'd1, 32'd0, 32'd0});

    // Reset in the 2nd element cycle of a 4-element load
    req_valid = 1'b1; req_op = 1'b0; req_base = 32'd4; req_stride = 32'd1; req_vl = 3'd4;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_reset_pre", {mem_re, mem_addr}, {1'b1, 32'd5});
    #2 rst = 1'b1;
    ref_reset();
    #1;
    check("mid_reset_now", {mem_re, mem_we, req_ready, rsp_valid}, {1'b0, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("mid_reset_quiet", {rsp_valid, mem_re, mem_we, req_ready}, {1'b0, 1'b0, 1'b0, 1'b1});
    end

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      op     = $urandom_range(0, 1) == 1;
      base   = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 34));
      stride = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 5));
      vl     = 3'($urandom_range(0, 7));
      wd     = {$urandom, $urandom, $urandom, $urandom};
      do_req(op, base, stride, vl, wd, $urandom_range(0, 3), rd, err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
